// File: rtl/bitwise_op_scheduler.sv
// Round-robin scheduler that time-shares one bitwise operator unit (a|b, logical OR, {~b,~a}) between NREQ requesters.
// Define BWOP_SCHED_STATS_EN to add saturating stat_grants/stat_stalls counters.
module bitwise_op_scheduler #(
  parameter int NREQ = 4,
  parameter int W = 3,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_or_bitwise,
  output logic              rsp_or_logical,
  output logic [2*W-1:0]    rsp_not
`ifdef BWOP_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_stalls
`endif
);

  // state | meaning
  // IDLE  | arbitrate; grant winner and capture its operands
  // EXEC  | operator unit evaluates captured operands into response regs
  // RESP  | response offered; wait for rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int SW = IDW + 1;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic [SW-1:0]  scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [W-1:0]   a_q, b_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   op_or_bitwise;
  logic           op_or_logical;
  logic [2*W-1:0] op_not;

  // first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + SW'(k);
      if (scan_sum >= SW'(NREQ)) scan_sum = scan_sum - SW'(NREQ);
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_any) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    op_or_bitwise = a_q | b_q;
    op_or_logical = (|a_q) || (|b_q);
    op_not        = {~b_q, ~a_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_or_bitwise <= '0;
      rsp_or_logical <= 1'b0;
      rsp_not        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q    <= req_a[int'(grant_id)*W +: W];
            b_q    <= req_b[int'(grant_id)*W +: W];
            id_q   <= grant_id;
            rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_id         <= id_q;
          rsp_or_bitwise <= op_or_bitwise;
          rsp_or_logical <= op_or_logical;
          rsp_not        <= op_not;
          rsp_valid      <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef BWOP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (state == IDLE && grant_any && stat_grants != 16'hFFFF)
        stat_grants <= stat_grants + 16'd1;
      if (state == RESP && !rsp_ready && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_op_scheduler.sv
// Self-checking bench for bitwise_op_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
module tb_bitwise_op_scheduler;
  localparam int NREQ = 4;
  localparam int W = 3;
  localparam int IDW = $clog2(NREQ);
  localparam int MASK = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_or_bitwise;
  logic              rsp_or_logical;
  logic [2*W-1:0]    rsp_not;
`ifdef BWOP_SCHED_STATS_EN
  logic [15:0]       stat_grants;
  logic [15:0]       stat_stalls;
`endif

  bitwise_op_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_or_bitwise(rsp_or_bitwise),
    .rsp_or_logical(rsp_or_logical), .rsp_not(rsp_not)
`ifdef BWOP_SCHED_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester side of the bench
  bit vld[NREQ];
  int op_a[NREQ];
  int op_b[NREQ];
  bit rdy;
  bit auto_drop;

  // transaction-level reference: 0 = idle, 1 = operating, 2 = offering response
  int m_phase, m_ptr, m_id, m_a, m_b;
  int e_id, e_orb, e_orl, e_not;
  int m_grants, m_stalls;

  logic [NREQ-1:0] obs_ready;
  logic            obs_valid;
  logic [IDW-1:0]  obs_id;
  logic [W-1:0]    obs_orb;
  logic            obs_orl;
  logic [2*W-1:0]  obs_not;
  int dut_grants[$];
  int grant_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (vld[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_index(input logic [NREQ-1:0] v);
    int idx = -1;
    for (int i = 0; i < NREQ; i++)
      if (((v >> i) & 1) != 0) idx = (idx == -1) ? i : -2;
    return idx;
  endfunction

  task automatic drive_inputs();
    logic [NREQ-1:0]   pv;
    logic [W*NREQ-1:0] pa, pb;
    pv = '0; pa = '0; pb = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pv = (pv << 1) | NREQ'(vld[i]);
      pa = (pa << W) | (W*NREQ)'(op_a[i] & MASK);
      pb = (pb << W) | (W*NREQ)'(op_b[i] & MASK);
    end
    req_valid = pv;
    req_a = pa;
    req_b = pb;
    rsp_ready = rdy;
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0;
    e_id = 0; e_orb = 0; e_orl = 0; e_not = 0;
    m_grants = 0; m_stalls = 0;
  endtask

  task automatic check_outputs();
`ifdef BWOP_SCHED_STATS_EN
    check_eq("stat_grants", stat_grants, m_grants);
    check_eq("stat_stalls", stat_stalls, m_stalls);
`endif
    check_eq("rsp_valid", rsp_valid, m_phase == 2);
    check_eq("rsp_id", rsp_id, e_id);
    check_eq("rsp_or_bitwise", rsp_or_bitwise, e_orb);
    check_eq("rsp_or_logical", rsp_or_logical, e_orl);
    check_eq("rsp_not", rsp_not, e_not);
  endtask

  // one clock: drive at negedge, check, then advance the model across the next rising edge
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    cyc++;
    drive_inputs();
    #1;
    g = (m_phase == 0) ? rr_pick(m_ptr) : -1;
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    check_eq("req_ready", req_ready, exp_ready);
    check_outputs();
    obs_ready = req_ready; obs_valid = rsp_valid; obs_id = rsp_id;
    obs_orb = rsp_or_bitwise; obs_orl = rsp_or_logical; obs_not = rsp_not;
    if (req_ready != '0) begin
      dut_grants.push_back(onehot_index(req_ready));
      grant_cyc.push_back(cyc);
    end
    case (m_phase)
      0: if (g >= 0) begin
        m_a = op_a[g]; m_b = op_b[g]; m_id = g;
        m_ptr = (g + 1) % NREQ;
        m_phase = 1;
        if (m_grants < 65535) m_grants++;
        if (auto_drop) vld[g] = 1'b0;
      end
      1: begin
        e_id  = m_id;
        e_orb = m_a | m_b;
        e_orl = (m_a != 0 || m_b != 0) ? 1 : 0;
        e_not = ((MASK - m_b) << W) + (MASK - m_a);
        m_phase = 2;
      end
      default: if (rdy) m_phase = 0; else if (m_stalls < 65535) m_stalls++;
    endcase
  endtask

  task automatic clear_requests();
    for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
  endtask

  // asserts reset away from the clock edge; outputs must fall without waiting for a clock
  task automatic apply_reset();
    @(negedge clk);
    clear_requests();
    vld[1] = 1'b1;
    drive_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_req_ready", req_ready, '0);
    check_outputs();
    @(negedge clk);
    clear_requests();
    drive_inputs();
    rst = 1'b0;
  endtask

  initial begin
    clear_requests();
    for (int i = 0; i < NREQ; i++) begin op_a[i] = 0; op_b[i] = 0; end
    rdy = 1'b1;
    auto_drop = 1'b1;
    model_reset();
    vld[2] = 1'b1;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("init_req_ready", req_ready, '0);
    check_outputs();
    clear_requests();
    drive_inputs();
    rst = 1'b0;

    // single request on slot 0
    vld[0] = 1'b1; op_a[0] = 3'b101; op_b[0] = 3'b000;
    step();
    check_eq("t1_grant", obs_ready, 4'b0001);
    step();
    check_eq("t1_exec_valid", obs_valid, 1'b0);
    step();
    check_eq("t1_valid", obs_valid, 1'b1);
    check_eq("t1_id", obs_id, 0);
    check_eq("t1_or_bitwise", obs_orb, 3'h5);
    check_eq("t1_or_logical", obs_orl, 1'b1);
    check_eq("t1_not", obs_not, 6'h3A);

    // single request on slot 2 with zero operands
    vld[2] = 1'b1; op_a[2] = 0; op_b[2] = 0;
    for (int i = 0; i < 3; i++) step();
    check_eq("t2_id", obs_id, 2);
    check_eq("t2_or_bitwise", obs_orb, 3'h0);
    check_eq("t2_or_logical", obs_orl, 1'b0);
    check_eq("t2_not", obs_not, 6'h3F);
    step();
    check_eq("t2_valid_fall", obs_valid, 1'b0);

    // all requesters continuously valid
    apply_reset();
    auto_drop = 1'b0;
    dut_grants.delete();
    grant_cyc.delete();
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b1; op_a[i] = i + 1; op_b[i] = (i * 3 + 2) & MASK;
    end
    for (int i = 0; i < 18; i++) step();
    check_eq("t3_grant_count", dut_grants.size(), 6);
    for (int i = 0; i < dut_grants.size() && i < 6; i++) begin
      check_eq("t3_grant_order", dut_grants[i], i % NREQ);
      if (i > 0) check_eq("t3_grant_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end

    // backpressure with slots 1 and 3 pending; pointer sits at 2
    auto_drop = 1'b1;
    clear_requests();
    vld[1] = 1'b1; op_a[1] = 3'b011; op_b[1] = 3'b100;
    vld[3] = 1'b1; op_a[3] = 3'b110; op_b[3] = 3'b001;
    rdy = 1'b0;
    step();
    check_eq("t4_first_grant", obs_ready, 4'b1000);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t4_stall_ready", obs_ready, '0);
    end
    rdy = 1'b1;
    step();
    step();
    check_eq("t4_next_grant", obs_ready, 4'b0010);
    for (int i = 0; i < 2; i++) step();

    // reset while a response is being offered (pointer at 2)
    apply_reset();
    vld[1] = 1'b1; op_a[1] = 3'b111; op_b[1] = 3'b010;
    rdy = 1'b0;
    step();
    step();
    @(posedge clk);
    #1;
    check_eq("t5_pre_rst_valid", rsp_valid, 1'b1);
    apply_reset();
    rdy = 1'b1;
    vld[0] = 1'b1; op_a[0] = 3'b001; op_b[0] = 3'b001;
    vld[3] = 1'b1; op_a[3] = 3'b100; op_b[3] = 3'b000;
    step();
    check_eq("t5_grant_after_rst", obs_ready, 4'b0001);
    for (int i = 0; i < 5; i++) step();

    // alternating slots 1 and 3
    apply_reset();
    auto_drop = 1'b0;
    dut_grants.delete();
    vld[1] = 1'b1; op_a[1] = 3'b010; op_b[1] = 3'b100;
    vld[3] = 1'b1; op_a[3] = 3'b010; op_b[3] = 3'b100;
    for (int i = 0; i < 3; i++) step();
    check_eq("t6_or_bitwise", obs_orb, 3'h6);
    check_eq("t6_or_logical", obs_orl, 1'b1);
    check_eq("t6_not", obs_not, 6'h1D);
    for (int i = 0; i < 9; i++) step();
    check_eq("t6_grant_count", dut_grants.size(), 4);
    for (int i = 0; i < dut_grants.size() && i < 4; i++)
      check_eq("t6_grant_order", dut_grants[i], (i % 2 == 0) ? 1 : 3);

    // randomized traffic with drops and backpressure
    auto_drop = 1'b1;
    clear_requests();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (vld[i]) begin
          if ($urandom_range(19) == 0) vld[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          vld[i] = 1'b1;
          op_a[i] = int'($urandom_range(MASK));
          op_b[i] = int'($urandom_range(MASK));
        end
      end
      rdy = ($urandom_range(3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_op_scheduler.md
Name: bitwise_op_scheduler

Overview:
- Time-shares one bitwise/logical operator unit between NREQ requesters using round-robin arbitration.
- The operator unit computes three results from operands a and b: bitwise OR, logical OR, and {~b, ~a}.
- The block grants one request, captures its operands, registers the results, and returns them on a single response channel tagged with the requester ID.
- It sits between several producer blocks and the shared operator datapath, which is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 3, operand width in bits.
- IDW, $clog2(NREQ), requester ID width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept strobe (one-hot or zero).
- req_a  in  W*NREQ  operand a; requester i uses bits [i*W +: W].
- req_b  in  W*NREQ  operand b; same packing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_or_bitwise  out  W  a | b.
- rsp_or_logical  out  1  (a != 0) || (b != 0).
- rsp_not  out  2*W  {~b, ~a}.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, all result outputs 0, req_ready=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the winner g is the first set req_valid at or after rr_ptr, searching upward modulo NREQ.
  - req_ready[g]=1 combinationally during that cycle; all other req_ready bits are 0.
  - On the clock edge: capture a_q/b_q from slot g, id_q=g, rr_ptr=(g+1) mod NREQ, go to EXEC.
  - With no request: stay in IDLE, req_ready=0.
- EXEC:
  - Drive the operator unit from a_q/b_q; register its three outputs and id_q into the response registers; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; all response fields held stable until the handshake.
  - On rsp_valid && rsp_ready: go to IDLE; rsp_valid falls on the next cycle.
  - req_ready=0 throughout RESP.
- Latency: accept edge at cycle N; rsp_valid is high from cycle N+2.
- Peak throughput: one operation every 3 cycles when rsp_ready is held high.
- Requesters must hold req_valid, req_a and req_b stable until req_ready is seen. Dropping req_valid before the grant is legal; that requester is simply not granted.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,NREQ-1,0,…
- A requester granted in IDLE is not re-arbitrated until the FSM returns to IDLE; no requests are queued.
- Arithmetic is pure bitwise; there is no carry or truncation. rsp_not upper W bits are ~b, lower W bits are ~a.
- Reset asserted mid-operation: any in-flight response is discarded and rsp_valid drops immediately (async). After release, arbitration restarts at requester 0.
- Response fields hold their last values in IDLE and EXEC; consumers qualify them with rsp_valid.

Optional Feature:
- Macro: BWOP_SCHED_STATS_EN.
- When defined, two outputs are added:
  - stat_grants [15:0]: increments on each IDLE grant.
  - stat_stalls [15:0]: increments on each RESP cycle with rsp_ready=0.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Single request, slot 0, a=3'b101, b=3'b000, rsp_ready=1 → rsp_valid at accept+2; rsp_id=0, or_bitwise=3'h5, or_logical=1, rsp_not=6'h3A.
- Slot 2, a=0, b=0 → rsp_id=2, or_bitwise=0, or_logical=0, rsp_not=6'h3F.
- All 4 requesters continuously valid with distinct operands, rsp_ready=1 → grants/rsp_id sequence 0,1,2,3,0,1; one grant every 3 cycles; each response matches its own slot's operands.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with slots 1 and 3 pending → response fields stable, req_ready stays 0; after the handshake the next grant goes to the slot after the previous winner. With BWOP_SCHED_STATS_EN, stat_stalls increases by 5.
- Reset mid-RESP (rsp_valid=1, rr_ptr=2) → rsp_valid=0 immediately; after release, slots 0 and 3 requesting → slot 0 granted first.
- Requests only on slots 1 and 3, a=3'b010, b=3'b100 → alternating 1,3,1,3; or_bitwise=3'h6, or_logical=1, rsp_not=6'h1D.
